// File: rtl/ray_tracer_pkg.sv
// Shared types and fixed-point constants for the multi-triangle ray tracer pipe.
package ray_tracer_pkg;

  localparam int X_W       = 10;
  localparam int Y_W       = 9;
  localparam int Z_W       = 3;
  localparam int QM        = 16;
  localparam int QF        = 16;
  localparam int FX_ONE    = 1 << QF;
  localparam int DRAIN_CYC = 3;

  // Intermediate widths: u_n/v_n numerators, Q(.QF) barycentrics, depth sum
  localparam int UN_W = X_W + Y_W + 3;
  localparam int U_W  = UN_W + QM + QF;
  localparam int ZS_W = U_W + Z_W + 3;

  // Edges, det and inv_det hold two's-complement values; accessors apply $signed()
  typedef struct packed {
    logic [X_W-1:0]   v0_x;
    logic [Y_W-1:0]   v0_y;
    logic [Z_W-1:0]   v0_z;
    logic [X_W:0]     e1_x;
    logic [Y_W:0]     e1_y;
    logic [Z_W:0]     e1_z;
    logic [X_W:0]     e2_x;
    logic [Y_W:0]     e2_y;
    logic [Z_W:0]     e2_z;
    logic [QM-1:0]    det;
    logic [QM+QF-1:0] inv_det;
    logic             en;
  } tri_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

endpackage

// File: rtl/ray_tracer_if.sv
// Table-write, pixel-request and result channels of ray_tracer_pipe.
interface ray_tracer_if #(
  parameter int NUM_TRI = 4,
  parameter int IDX_W   = (NUM_TRI > 1) ? $clog2(NUM_TRI) : 1
);
  import ray_tracer_pkg::*;

  logic                     tri_wr_valid;
  logic                     tri_wr_ready;
  logic [IDX_W-1:0]         tri_wr_idx;
  logic                     tri_wr_en;
  logic [X_W-1:0]           v0_x;
  logic [Y_W-1:0]           v0_y;
  logic [Z_W-1:0]           v0_z;
  logic signed [X_W:0]      e1_x;
  logic signed [Y_W:0]      e1_y;
  logic signed [Z_W:0]      e1_z;
  logic signed [X_W:0]      e2_x;
  logic signed [Y_W:0]      e2_y;
  logic signed [Z_W:0]      e2_z;
  logic signed [QM-1:0]     det;
  logic signed [QM+QF-1:0]  inv_det;

  logic                     px_valid;
  logic                     px_ready;
  logic [X_W-1:0]           px_col;
  logic [Y_W-1:0]           px_row;

  logic                     out_valid;
  logic                     out_ready;
  logic                     out_hit;
  logic [IDX_W-1:0]         out_tri_idx;
  logic [Z_W-1:0]           out_z;

  modport slave (
    input  tri_wr_valid, tri_wr_idx, tri_wr_en, v0_x, v0_y, v0_z,
           e1_x, e1_y, e1_z, e2_x, e2_y, e2_z, det, inv_det,
           px_valid, px_col, px_row, out_ready,
    output tri_wr_ready, px_ready, out_valid, out_hit, out_tri_idx, out_z
  );

  modport master (
    output tri_wr_valid, tri_wr_idx, tri_wr_en, v0_x, v0_y, v0_z,
           e1_x, e1_y, e1_z, e2_x, e2_y, e2_z, det, inv_det,
           px_valid, px_col, px_row, out_ready,
    input  tri_wr_ready, px_ready, out_valid, out_hit, out_tri_idx, out_z
  );

endinterface

// File: rtl/ray_tri_eval.sv
// Three-stage barycentric evaluator: one triangle per cycle, idx/valid ride along.
// BACKFACE_CULL_EN: when defined, triangles with det<0 never report inside.
module ray_tri_eval
  import ray_tracer_pkg::*;
#(
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_vld,
  input  logic [IDX_W-1:0] i_idx,
  input  tri_t             i_tri,
  input  logic [X_W-1:0]   i_col,
  input  logic [Y_W-1:0]   i_row,
  output logic             o_vld,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_inside,
  output logic [Z_W-1:0]   o_z
);

  localparam logic signed [U_W:0]    ONE_Q   = (U_W+1)'(FX_ONE);
  localparam logic signed [ZS_W-1:0] Z_MAX_S = ZS_W'((1 << Z_W) - 1);

  // Floor a Q(.QF) depth sum to an integer and saturate into [0, 2^Z_W-1]
  function automatic logic [Z_W-1:0] floor_clamp_z(input logic signed [ZS_W-1:0] s);
    logic signed [ZS_W-1:0] f;
    f = s >>> QF;
    if (f[ZS_W-1])         return '0;
    else if (f > Z_MAX_S)  return '1;
    else                   return f[Z_W-1:0];
  endfunction

  // ---- stage 1 (p0 -> p1): pixel offset and edge-function numerators ----
  logic signed [X_W:0]    w_tx_p0, w_e1x_p0, w_e2x_p0;
  logic signed [Y_W:0]    w_ty_p0, w_e1y_p0, w_e2y_p0;
  logic signed [UN_W-1:0] w_un_p0, w_vn_p0;

  // Offset of the pixel from V0 and the unnormalised u/v numerators
  always_comb begin
    w_e1x_p0 = $signed(i_tri.e1_x);
    w_e2x_p0 = $signed(i_tri.e2_x);
    w_e1y_p0 = $signed(i_tri.e1_y);
    w_e2y_p0 = $signed(i_tri.e2_y);
    w_tx_p0  = $signed({1'b0, i_col}) - $signed({1'b0, i_tri.v0_x});
    w_ty_p0  = $signed({1'b0, i_row}) - $signed({1'b0, i_tri.v0_y});
    w_un_p0  = UN_W'(w_tx_p0) * UN_W'(w_e2y_p0) - UN_W'(w_ty_p0) * UN_W'(w_e2x_p0);
    w_vn_p0  = UN_W'(w_e1x_p0) * UN_W'(w_ty_p0) - UN_W'(w_e1y_p0) * UN_W'(w_tx_p0);
  end

  logic                     r_vld_p1;
  logic [IDX_W-1:0]         r_idx_p1;
  logic signed [UN_W-1:0]   r_un_p1, r_vn_p1;
  logic signed [QM+QF-1:0]  r_inv_p1;
  logic signed [QM-1:0]     r_det_p1;
  logic                     r_en_p1;
  logic [Z_W-1:0]           r_v0z_p1;
  logic signed [Z_W:0]      r_e1z_p1, r_e2z_p1;

  // ---- stage 2 (p1 -> p2): scale numerators by 1/det ----
  logic                     r_vld_p2;
  logic [IDX_W-1:0]         r_idx_p2;
  logic signed [U_W-1:0]    r_u_p2, r_v_p2;
  logic signed [QM-1:0]     r_det_p2;
  logic                     r_en_p2;
  logic [Z_W-1:0]           r_v0z_p2;
  logic signed [Z_W:0]      r_e1z_p2, r_e2z_p2;

  // Valid flags are the only pipeline state cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= i_vld;
      r_vld_p2 <= r_vld_p1;
    end
  end

  // Datapath registers for stages 1 and 2
  always_ff @(posedge clk) begin
    r_idx_p1 <= i_idx;
    r_un_p1  <= w_un_p0;
    r_vn_p1  <= w_vn_p0;
    r_inv_p1 <= $signed(i_tri.inv_det);
    r_det_p1 <= $signed(i_tri.det);
    r_en_p1  <= i_tri.en;
    r_v0z_p1 <= i_tri.v0_z;
    r_e1z_p1 <= $signed(i_tri.e1_z);
    r_e2z_p1 <= $signed(i_tri.e2_z);

    r_idx_p2 <= r_idx_p1;
    r_u_p2   <= U_W'(r_un_p1) * U_W'(r_inv_p1);
    r_v_p2   <= U_W'(r_vn_p1) * U_W'(r_inv_p1);
    r_det_p2 <= r_det_p1;
    r_en_p2  <= r_en_p1;
    r_v0z_p2 <= r_v0z_p1;
    r_e1z_p2 <= r_e1z_p1;
    r_e2z_p2 <= r_e2z_p1;
  end

  // ---- stage 3 (p2 -> outputs): coverage test and interpolated depth ----
  logic signed [U_W:0]    w_uv_sum;
  logic signed [ZS_W-1:0] w_zsum;
  logic                   w_wind_ok;

  // Inclusive-edge inside test and floor/clamped depth
  always_comb begin
`ifdef BACKFACE_CULL_EN
    w_wind_ok = (r_det_p2 > 0);
`else
    w_wind_ok = (r_det_p2 != 0);
`endif
    w_uv_sum = (U_W+1)'(r_u_p2) + (U_W+1)'(r_v_p2);
    w_zsum   = (ZS_W'($signed({1'b0, r_v0z_p2})) <<< QF)
             + ZS_W'(r_u_p2) * ZS_W'(r_e1z_p2)
             + ZS_W'(r_v_p2) * ZS_W'(r_e2z_p2);
    o_vld    = r_vld_p2;
    o_idx    = r_idx_p2;
    o_inside = r_en_p2 && w_wind_ok && !r_u_p2[U_W-1] && !r_v_p2[U_W-1]
               && (w_uv_sum <= ONE_Q);
    o_z      = floor_clamp_z(w_zsum);
  end

endmodule

// File: rtl/ray_tracer_pipe.sv
// Multi-triangle ray tracer: triangle table, issue/drain FSM, nearest-hit depth
// test and result handshake. Backface culling is selected by BACKFACE_CULL_EN.
module ray_tracer_pipe
  import ray_tracer_pkg::*;
#(
  parameter int NUM_TRI = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  ray_tracer_if.slave  io_rt
);

  localparam int IDX_W = (NUM_TRI > 1) ? $clog2(NUM_TRI) : 1;

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [1:0]        r_drain;
  logic              w_idle, w_issue, w_out_valid;
  logic              w_issue_last, w_drain_last;
  logic              w_px_acc, w_wr;

  tri_t              r_tbl [NUM_TRI];
  logic [NUM_TRI-1:0] r_en;
  tri_t              w_wr_tri, w_issue_tri;

  logic [X_W-1:0]    r_col;
  logic [Y_W-1:0]    r_row;

  logic              w_ev_vld, w_ev_inside, w_take;
  logic [IDX_W-1:0]  w_ev_idx;
  logic [Z_W-1:0]    w_ev_z;

  logic              r_best_hit;
  logic [IDX_W-1:0]  r_best_idx;
  logic [Z_W-1:0]    r_best_z;

  logic              r_out_hit;
  logic [IDX_W-1:0]  r_out_idx;
  logic [Z_W-1:0]    r_out_z;

  assign w_issue_last = (r_idx == IDX_W'(NUM_TRI - 1));
  assign w_drain_last = (r_drain == 2'(DRAIN_CYC - 1));
  assign w_px_acc     = io_rt.px_valid && w_idle;
  assign w_wr         = io_rt.tri_wr_valid && w_idle;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state: accept, issue every slot, drain the pipe, hold the result
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (io_rt.px_valid)  w_state_nxt = ISSUE;
      ISSUE:   if (w_issue_last)    w_state_nxt = DRAIN;
      DRAIN:   if (w_drain_last)    w_state_nxt = DONE;
      DONE:    if (io_rt.out_ready) w_state_nxt = IDLE;
      default:                      w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: both request channels are open only while idle
  always_comb begin
    w_idle      = (r_state == IDLE);
    w_issue     = (r_state == ISSUE);
    w_out_valid = (r_state == DONE);
  end

  // Issue index and drain counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_drain <= '0;
    end else begin
      case (r_state)
        ISSUE:   r_idx   <= r_idx + 1'b1;
        DRAIN:   r_drain <= r_drain + 1'b1;
        default: begin
          r_idx   <= '0;
          r_drain <= '0;
        end
      endcase
    end
  end

  // Pack the write payload; read the issued slot with its live enable bit
  always_comb begin
    w_wr_tri.v0_x    = io_rt.v0_x;
    w_wr_tri.v0_y    = io_rt.v0_y;
    w_wr_tri.v0_z    = io_rt.v0_z;
    w_wr_tri.e1_x    = io_rt.e1_x;
    w_wr_tri.e1_y    = io_rt.e1_y;
    w_wr_tri.e1_z    = io_rt.e1_z;
    w_wr_tri.e2_x    = io_rt.e2_x;
    w_wr_tri.e2_y    = io_rt.e2_y;
    w_wr_tri.e2_z    = io_rt.e2_z;
    w_wr_tri.det     = io_rt.det;
    w_wr_tri.inv_det = io_rt.inv_det;
    w_wr_tri.en      = io_rt.tri_wr_en;
    w_issue_tri      = r_tbl[r_idx];
    w_issue_tri.en   = r_en[r_idx];
  end

  // Triangle geometry table (not reset) and latched pixel coordinate
  always_ff @(posedge clk) begin
    if (w_wr)     r_tbl[io_rt.tri_wr_idx] <= w_wr_tri;
    if (w_px_acc) begin
      r_col <= io_rt.px_col;
      r_row <= io_rt.px_row;
    end
  end

  // Slot enables: reset clears every slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_en <= '0;
    else if (w_wr) r_en[io_rt.tri_wr_idx] <= io_rt.tri_wr_en;
  end

  ray_tri_eval #(.IDX_W(IDX_W)) u_eval (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_vld    (w_issue),
    .i_idx    (r_idx),
    .i_tri    (w_issue_tri),
    .i_col    (r_col),
    .i_row    (r_row),
    .o_vld    (w_ev_vld),
    .o_idx    (w_ev_idx),
    .o_inside (w_ev_inside),
    .o_z      (w_ev_z)
  );

  // Strictly nearer hits replace the best, so equal depths keep the lower index
  assign w_take = w_ev_vld && w_ev_inside && (!r_best_hit || (w_ev_z < r_best_z));

  // Running hit flag, cleared when a new pixel is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_best_hit <= 1'b0;
    else if (w_px_acc) r_best_hit <= 1'b0;
    else if (w_take)   r_best_hit <= 1'b1;
  end

  // Running winner index/depth, zeroed at accept so a miss reports 0/0
  always_ff @(posedge clk) begin
    if (w_px_acc) begin
      r_best_idx <= '0;
      r_best_z   <= '0;
    end else if (w_take) begin
      r_best_idx <= w_ev_idx;
      r_best_z   <= w_ev_z;
    end
  end

  // Result registers loaded as the last triangle leaves the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_hit <= 1'b0;
      r_out_idx <= '0;
      r_out_z   <= '0;
    end else if ((r_state == DRAIN) && w_drain_last) begin
      r_out_hit <= r_best_hit;
      r_out_idx <= r_best_idx;
      r_out_z   <= r_best_z;
    end
  end

  assign io_rt.tri_wr_ready = w_idle;
  assign io_rt.px_ready     = w_idle;
  assign io_rt.out_valid    = w_out_valid;
  assign io_rt.out_hit      = r_out_hit;
  assign io_rt.out_tri_idx  = r_out_idx;
  assign io_rt.out_z        = r_out_z;

endmodule

// File: tb/tb_ray_tracer_pipe.sv
// Directed bench for ray_tracer_pipe with hand-computed expectations.
module tb_ray_tracer_pipe;
  import ray_tracer_pkg::*;

  localparam int NUM_TRI = 4;
  localparam int LAT     = NUM_TRI + 3;
`ifdef BACKFACE_CULL_EN
  localparam logic SWAP_HIT = 1'b0;
  localparam int   SWAP_Z   = 0;
`else
  localparam logic SWAP_HIT = 1'b1;
  localparam int   SWAP_Z   = 2;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  ray_tracer_if #(.NUM_TRI(NUM_TRI)) rt();

  ray_tracer_pipe #(.NUM_TRI(NUM_TRI)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_rt (rt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_tri(input int idx, input int en,
                           input int v0x, input int v0y, input int v0z,
                           input int e1x, input int e1y, input int e1z,
                           input int e2x, input int e2y, input int e2z,
                           input int det, input int inv);
    @(negedge clk);
    rt.tri_wr_idx   = 2'(idx);
    rt.tri_wr_en    = 1'(en);
    rt.v0_x         = X_W'(v0x);
    rt.v0_y         = Y_W'(v0y);
    rt.v0_z         = Z_W'(v0z);
    rt.e1_x         = (X_W+1)'(e1x);
    rt.e1_y         = (Y_W+1)'(e1y);
    rt.e1_z         = (Z_W+1)'(e1z);
    rt.e2_x         = (X_W+1)'(e2x);
    rt.e2_y         = (Y_W+1)'(e2y);
    rt.e2_z         = (Z_W+1)'(e2z);
    rt.det          = QM'(det);
    rt.inv_det      = (QM+QF)'(inv);
    rt.tri_wr_valid = 1'b1;
    chk("wr_ready", rt.tri_wr_ready, 1);
    @(posedge clk);
    #1 rt.tri_wr_valid = 1'b0;
  endtask

  task automatic run_pixel(input string tag, input int col, input int row,
                           input logic hit, input int idx, input int z, input int hold);
    int lat;
    lat = 0;
    @(negedge clk);
    rt.px_col   = X_W'(col);
    rt.px_row   = Y_W'(row);
    rt.px_valid = 1'b1;
    chk({tag, ".px_ready"}, rt.px_ready, 1);
    @(posedge clk);
    #1 rt.px_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (rt.out_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, ".latency"}, lat, LAT);
    chk({tag, ".hit"}, rt.out_hit, hit);
    chk({tag, ".idx"}, rt.out_tri_idx, idx);
    chk({tag, ".z"}, rt.out_z, z);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, rt.out_valid, 1);
      chk({tag, ".hold_hit"}, rt.out_hit, hit);
      chk({tag, ".hold_idx"}, rt.out_tri_idx, idx);
      chk({tag, ".hold_z"}, rt.out_z, z);
      chk({tag, ".hold_px_ready"}, rt.px_ready, 0);
      chk({tag, ".hold_wr_ready"}, rt.tri_wr_ready, 0);
    end
    @(negedge clk);
    rt.out_ready = 1'b1;
    @(posedge clk);
    #1 rt.out_ready = 1'b0;
    chk({tag, ".idle_px_ready"}, rt.px_ready, 1);
    chk({tag, ".idle_valid"}, rt.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rt.tri_wr_valid = 1'b0;
    rt.tri_wr_idx   = '0;
    rt.tri_wr_en    = 1'b0;
    rt.v0_x = '0; rt.v0_y = '0; rt.v0_z = '0;
    rt.e1_x = '0; rt.e1_y = '0; rt.e1_z = '0;
    rt.e2_x = '0; rt.e2_y = '0; rt.e2_z = '0;
    rt.det  = '0; rt.inv_det = '0;
    rt.px_valid = 1'b0; rt.px_col = '0; rt.px_row = '0;
    rt.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", rt.out_valid, 0);
    chk("rst.out_hit", rt.out_hit, 0);
    chk("rst.out_idx", rt.out_tri_idx, 0);
    chk("rst.out_z", rt.out_z, 0);
    chk("rst.px_ready", rt.px_ready, 1);
    chk("rst.wr_ready", rt.tri_wr_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: empty table
    run_pixel("t1", 5, 5, 1'b0, 0, 0, 0);

    // 2: single triangle, inside and outside
    write_tri(0, 1, 0, 0, 2, 40, 0, 0, 0, 40, 0, 1600, 41);
    run_pixel("t2a", 10, 10, 1'b1, 0, 2, 0);
    run_pixel("t2b", 35, 35, 1'b0, 0, 0, 0);

    // 3: depth test and tie to lower index
    write_tri(0, 1, 0, 0, 5, 40, 0, 0, 0, 40, 0, 1600, 41);
    write_tri(1, 1, 0, 0, 3, 40, 0, 0, 0, 40, 0, 1600, 41);
    run_pixel("t3a", 10, 10, 1'b1, 1, 3, 0);
    write_tri(1, 1, 0, 0, 5, 40, 0, 0, 0, 40, 0, 1600, 41);
    run_pixel("t3b", 10, 10, 1'b1, 0, 5, 0);

    // 4: result held under back-pressure
    run_pixel("t4", 10, 10, 1'b1, 0, 5, 5);

    // 3': highest slot wins when nearest
    write_tri(3, 1, 0, 0, 1, 40, 0, 0, 0, 40, 0, 1600, 41);
    run_pixel("t3c", 10, 10, 1'b1, 3, 1, 0);
    write_tri(3, 0, 0, 0, 1, 40, 0, 0, 0, 40, 0, 1600, 41);
    write_tri(1, 0, 0, 0, 5, 40, 0, 0, 0, 40, 0, 1600, 41);

    // 5: degenerate and reversed winding
    write_tri(0, 1, 0, 0, 2, 40, 0, 0, 0, 40, 0, 0, 41);
    run_pixel("t5a", 10, 10, 1'b0, 0, 0, 0);
    write_tri(0, 1, 0, 0, 2, 0, 40, 0, 40, 0, 0, -1600, -41);
    run_pixel("t5b", 10, 10, SWAP_HIT, 0, SWAP_Z, 0);

    // Depth interpolation, vertex corner, clamping, negative barycentric
    write_tri(0, 1, 0, 0, 0, 40, 0, 4, 0, 40, 0, 1600, 41);
    run_pixel("zint", 20, 0, 1'b1, 0, 2, 0);
    run_pixel("corner", 0, 0, 1'b1, 0, 0, 0);
    write_tri(0, 1, 0, 0, 7, 40, 0, 7, 0, 40, 0, 1600, 41);
    run_pixel("clamp_hi", 20, 0, 1'b1, 0, 7, 0);
    write_tri(0, 1, 0, 0, 0, 40, 0, -8, 0, 40, 0, 1600, 41);
    run_pixel("clamp_lo", 20, 0, 1'b1, 0, 0, 0);
    write_tri(0, 1, 10, 10, 1, 40, 0, 0, 0, 40, 0, 1600, 41);
    run_pixel("neg_u", 5, 10, 1'b0, 0, 0, 0);
    run_pixel("v0_hit", 10, 10, 1'b1, 0, 1, 0);

    // 6: reset during drain aborts the pixel and clears enables
    write_tri(0, 1, 0, 0, 2, 40, 0, 0, 0, 40, 0, 1600, 41);
    @(negedge clk);
    rt.px_col = X_W'(10);
    rt.px_row = Y_W'(10);
    rt.px_valid = 1'b1;
    @(posedge clk);
    #1 rt.px_valid = 1'b0;
    repeat (NUM_TRI + 1) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6.rst_valid", rt.out_valid, 0);
    chk("t6.rst_px_ready", rt.px_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (rt.out_valid) seen = 1'b1;
    end
    chk("t6.no_result", seen, 0);
    run_pixel("t6", 10, 10, 1'b0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
